// File: rtl/pc_seq_ctrl_pkg.sv
// pc_seq_ctrl_pkg
//   Shared definitions for the next-PC sequencer: instruction address bus
//   width, boot and exception vectors, counter width and FSM state encoding.
//   No ports (package).

`ifndef InstAddrBus
`define InstAddrBus 63:0
`endif

package pc_seq_ctrl_pkg;

   // Address width follows the core-wide instruction address bus.
   typedef logic [`InstAddrBus] inst_addr_t;
   localparam int ADDR_W_DEF = $bits(inst_addr_t);

   localparam logic [63:0] RESET_VEC_DEF = 64'h0000_0000_0000_0000;
   localparam logic [63:0] EXC_VEC_DEF   = 64'h0000_0000_0000_0400;
   localparam int          CNT_W_DEF     = 32;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'b00,
      ST_RUN   = 2'b01,
      ST_REDIR = 2'b10,
      ST_HALT  = 2'b11
   } seq_state_t;

endpackage

// File: rtl/pc_seq_ctrl_sat_counter.sv
// sat_counter
//   W-bit counter that increments on inc and sticks at all-ones.
//   Ports:
//     clk   in  1  clock
//     rst   in  1  asynchronous active-low reset (0 = reset)
//     inc   in  1  count one event this cycle
//     clear in  1  synchronous clear (wins over inc)
//     count out W  current count

module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] count
);

   // Saturating count register with synchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl
//   Next-PC sequencer for the fetch stage. Chooses every cycle between
//   incrementing the PC, holding it, or loading a latched redirect target,
//   and drives the IF/ID and ID/EX flushes, fetch_valid and the halt flag.
//   Ports:
//     clk         in  1       clock
//     rst         in  1       asynchronous active-low reset (0 = reset)
//     pc_cur      in  ADDR_W  current PC value
//     br_taken    in  1       EX stage: branch taken this cycle
//     br_target   in  ADDR_W  EX stage: branch target (bits [1:0] ignored)
//     exc_req     in  1       exception / IRQ request (level)
//     stall_req   in  1       hazard unit: hold the PC
//     imem_ready  in  1       instruction memory accepts a fetch
//     halt_req    in  1       WFI decoded in ID
//     pc_src      out 1       1 = PC loads pc_in, 0 = PC increments by 4
//     pc_in       out ADDR_W  PC load value
//     flush_if    out 1       invalidate IF/ID
//     flush_id    out 1       invalidate ID/EX
//     fetch_valid out 1       current PC is a real fetch
//     halted      out 1       core is halted
//     redir_cnt   out CNT_W   saturating count of redirects

module pc_seq_ctrl
   import pc_seq_ctrl_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF),
   parameter int                CNT_W     = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_cur,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              exc_req,
   input  logic              stall_req,
   input  logic              imem_ready,
   input  logic              halt_req,
   output logic              pc_src,
   output logic [ADDR_W-1:0] pc_in,
   output logic              flush_if,
   output logic              flush_id,
   output logic              fetch_valid,
   output logic              halted,
   output logic [CNT_W-1:0]  redir_cnt
);

   seq_state_t        state;
   logic [ADDR_W-1:0] tgt_q;
   logic [ADDR_W-1:0] redir_tgt;
   logic              redir_new;
   logic              hold;
   logic              cnt_clr;
   logic              unused_tgt_bits;

   // Branch targets are word aligned; the low bits carry no information.
   assign unused_tgt_bits = ^br_target[1:0];

   // Select the redirect target and decide whether a redirect is taken now.
   // Exceptions beat branches; in HALT only an exception wakes the core.
   always_comb begin
      redir_tgt = exc_req ? EXC_VEC : {br_target[ADDR_W-1:2], 2'b00};
      case (state)
         ST_RUN:   redir_new = exc_req | br_taken;
         ST_REDIR: redir_new = exc_req | br_taken;
         ST_HALT:  redir_new = exc_req;
         default:  redir_new = 1'b0;
      endcase
   end

   // Sequencer FSM and latched redirect target.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_BOOT;
         tgt_q <= '0;
      end else if (redir_new) begin
         // A redirect also cancels a same-cycle halt request (its WFI sits
         // in a slot about to be flushed).
         state <= ST_REDIR;
         tgt_q <= redir_tgt;
      end else begin
         tgt_q <= tgt_q;
         case (state)
            ST_BOOT:  state <= ST_RUN;
            ST_RUN:   state <= halt_req ? ST_HALT : ST_RUN;
            ST_REDIR: state <= ST_RUN;
            ST_HALT:  state <= ST_HALT;
            default:  state <= ST_BOOT;
         endcase
      end
   end

   assign hold = stall_req | ~imem_ready;

   // Next-PC mux and per-state control outputs. BOOT values double as the
   // reset values because reset forces the state to BOOT asynchronously.
   always_comb begin
      pc_src      = 1'b1;
      pc_in       = RESET_VEC;
      flush_if    = 1'b1;
      flush_id    = 1'b1;
      fetch_valid = 1'b0;
      halted      = 1'b0;
      case (state)
         ST_BOOT: begin
            pc_in = RESET_VEC;
         end
         ST_REDIR: begin
            // Redirect overrides stall and back-pressure.
            pc_in = tgt_q;
         end
         ST_HALT: begin
            pc_in    = pc_cur;
            flush_id = 1'b0;
            halted   = 1'b1;
         end
         ST_RUN: begin
            if (hold) begin
               pc_src      = 1'b1;
               pc_in       = pc_cur;
               flush_if    = ~imem_ready;
               flush_id    = stall_req;
               fetch_valid = imem_ready;
            end else begin
               pc_src      = 1'b0;
               pc_in       = pc_cur + ADDR_W'(3'd4);
               flush_if    = 1'b0;
               flush_id    = 1'b0;
               fetch_valid = 1'b1;
            end
         end
         default: begin
            pc_in = RESET_VEC;
         end
      endcase
   end

   // Count each redirect once, when its target is latched.
   assign cnt_clr = (state == ST_BOOT);

   sat_counter #(
      .W(CNT_W)
   ) u_redir_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (redir_new),
      .clear (cnt_clr),
      .count (redir_cnt)
   );

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl
//   Self-checking bench for pc_seq_ctrl: a hand-derived vector table from
//   reset, directed saturation / halt / async-reset sequences, and random
//   stimulus compared with a behavioural model. The bench owns the PC
//   register and feeds it back as pc_cur.

module tb_pc_seq_ctrl;
   import pc_seq_ctrl_pkg::*;

   localparam int          CW   = 4;
   localparam int          CMAX = 15;
   localparam logic [63:0] EXC  = 64'h400;
   localparam logic [63:0] RV   = 64'h0;

   logic          clk, rst;
   logic [63:0]   pc_cur, br_target, pc_in, pc_reg;
   logic          br_taken, exc_req, stall_req, imem_ready, halt_req;
   logic          pc_src, flush_if, flush_id, fetch_valid, halted;
   logic [CW-1:0] redir_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model: boot pending, halted, pending target queue, count.
   bit          m_boot;
   bit          m_halt;
   logic [63:0] m_pend[$];
   int          m_cnt;

   typedef struct {
      logic exc, br; logic [63:0] tgt; logic stall, rdy, hlt;
      logic [63:0] pc; logic src; logic [63:0] pin;
      logic fi, fid, fv, hl; int cnt;
   } row_t;
   row_t rows[25];

   assign pc_cur = pc_reg;

   pc_seq_ctrl #(
      .ADDR_W(64), .RESET_VEC(64'h0), .EXC_VEC(64'h400), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst), .pc_cur(pc_cur), .br_taken(br_taken),
      .br_target(br_target), .exc_req(exc_req), .stall_req(stall_req),
      .imem_ready(imem_ready), .halt_req(halt_req), .pc_src(pc_src),
      .pc_in(pc_in), .flush_if(flush_if), .flush_id(flush_id),
      .fetch_valid(fetch_valid), .halted(halted), .redir_cnt(redir_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic row_t mk(input logic exc, br, input logic [63:0] tgt,
                               input logic stall, rdy, hlt, input logic [63:0] pc,
                               input logic src, input logic [63:0] pin,
                               input logic fi, fid, fv, hl, input int cnt);
      row_t r;
      r.exc = exc; r.br = br; r.tgt = tgt; r.stall = stall; r.rdy = rdy;
      r.hlt = hlt; r.pc = pc; r.src = src; r.pin = pin; r.fi = fi;
      r.fid = fid; r.fv = fv; r.hl = hl; r.cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic idle_inputs();
      exc_req = 1'b0; br_taken = 1'b0; br_target = 64'h0;
      stall_req = 1'b0; imem_ready = 1'b1; halt_req = 1'b0;
   endtask

   task automatic chk_reset_outs(input string p);
      chk({p, "_src"}, 64'(pc_src), 64'd1);
      chk({p, "_pc_in"}, pc_in, RV);
      chk({p, "_fi"}, 64'(flush_if), 64'd1);
      chk({p, "_fid"}, 64'(flush_id), 64'd1);
      chk({p, "_fv"}, 64'(fetch_valid), 64'd0);
      chk({p, "_halted"}, 64'(halted), 64'd0);
      chk({p, "_cnt"}, 64'(redir_cnt), 64'd0);
   endtask

   // Called at the negedge: capture the PC controls, cross the edge, update the PC.
   task automatic advance();
      logic        s;
      logic [63:0] v;
      s = pc_src; v = pc_in;
      @(posedge clk);
      #1;
      pc_reg = s ? v : pc_reg + 64'd4;
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      pc_reg = 64'h0;
      idle_inputs();
      @(posedge clk);
      #1;
      chk_reset_outs("reset");
      @(posedge clk);
      #1;
      rst = 1'b1;
      m_boot = 1'b1; m_halt = 1'b0; m_pend.delete(); m_cnt = 0;
   endtask

   task automatic model_cycle(input string p);
      logic        e_src, e_fi, e_fid, e_fv, e_hl;
      logic [63:0] e_pin;
      @(negedge clk);
      if (m_boot) begin
         e_src = 1; e_pin = RV; e_fi = 1; e_fid = 1; e_fv = 0; e_hl = 0;
      end else if (m_pend.size() != 0) begin
         e_src = 1; e_pin = m_pend[0]; e_fi = 1; e_fid = 1; e_fv = 0; e_hl = 0;
      end else if (m_halt) begin
         e_src = 1; e_pin = pc_reg; e_fi = 1; e_fid = 0; e_fv = 0; e_hl = 1;
      end else if (stall_req || !imem_ready) begin
         e_src = 1; e_pin = pc_reg; e_fi = !imem_ready; e_fid = stall_req;
         e_fv = imem_ready; e_hl = 0;
      end else begin
         e_src = 0; e_pin = pc_reg + 64'd4; e_fi = 0; e_fid = 0; e_fv = 1; e_hl = 0;
      end
      chk({p, "_src"}, 64'(pc_src), 64'(e_src));
      chk({p, "_pc_in"}, pc_in, e_pin);
      chk({p, "_fi"}, 64'(flush_if), 64'(e_fi));
      chk({p, "_fid"}, 64'(flush_id), 64'(e_fid));
      chk({p, "_fv"}, 64'(fetch_valid), 64'(e_fv));
      chk({p, "_halted"}, 64'(halted), 64'(e_hl));
      chk({p, "_cnt"}, 64'(redir_cnt), 64'(m_cnt));
      // Requests seen at the coming edge.
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (exc_req || (br_taken && !m_halt)) begin
         m_pend.delete();
         m_pend.push_back(exc_req ? EXC : (br_target & ~64'h3));
         m_halt = 1'b0;
         if (m_cnt < CMAX) m_cnt++;
      end else if (m_pend.size() != 0) begin
         m_pend.delete();
      end else if (halt_req) begin
         m_halt = 1'b1;
      end
      advance();
   endtask

   task automatic apply_row(input int i);
      row_t  r;
      string p;
      r = rows[i];
      p = $sformatf("row%0d", i);
      exc_req = r.exc; br_taken = r.br; br_target = r.tgt;
      stall_req = r.stall; imem_ready = r.rdy; halt_req = r.hlt;
      @(negedge clk);
      chk({p, "_pc"}, pc_reg, r.pc);
      chk({p, "_src"}, 64'(pc_src), 64'(r.src));
      chk({p, "_pc_in"}, pc_in, r.pin);
      chk({p, "_fi"}, 64'(flush_if), 64'(r.fi));
      chk({p, "_fid"}, 64'(flush_id), 64'(r.fid));
      chk({p, "_fv"}, 64'(fetch_valid), 64'(r.fv));
      chk({p, "_halted"}, 64'(halted), 64'(r.hl));
      chk({p, "_cnt"}, 64'(redir_cnt), 64'(r.cnt));
      advance();
   endtask

   initial begin
      logic [63:0] frozen;
      //             exc br tgt      st rdy hlt  pc       src pin      fi fid fv hl cnt
      rows[0]  = mk(0, 0, 64'h0,    0, 1, 0, 64'h0,    1, 64'h0,    1, 1, 0, 0, 0);
      rows[1]  = mk(0, 0, 64'h0,    0, 1, 0, 64'h0,    0, 64'h4,    0, 0, 1, 0, 0);
      rows[2]  = mk(0, 0, 64'h0,    0, 1, 0, 64'h4,    0, 64'h8,    0, 0, 1, 0, 0);
      rows[3]  = mk(0, 1, 64'h1003, 0, 1, 0, 64'h8,    0, 64'hC,    0, 0, 1, 0, 0);
      rows[4]  = mk(0, 0, 64'h0,    0, 1, 0, 64'hC,    1, 64'h1000, 1, 1, 0, 0, 1);
      rows[5]  = mk(1, 1, 64'h2000, 0, 1, 0, 64'h1000, 0, 64'h1004, 0, 0, 1, 0, 1);
      rows[6]  = mk(0, 0, 64'h0,    0, 1, 0, 64'h1004, 1, 64'h400,  1, 1, 0, 0, 2);
      rows[7]  = mk(0, 0, 64'h0,    0, 1, 0, 64'h400,  0, 64'h404,  0, 0, 1, 0, 2);
      rows[8]  = mk(0, 0, 64'h0,    1, 1, 0, 64'h404,  1, 64'h404,  0, 1, 1, 0, 2);
      rows[9]  = mk(0, 0, 64'h0,    1, 1, 0, 64'h404,  1, 64'h404,  0, 1, 1, 0, 2);
      rows[10] = mk(0, 0, 64'h0,    1, 1, 0, 64'h404,  1, 64'h404,  0, 1, 1, 0, 2);
      rows[11] = mk(0, 0, 64'h0,    0, 1, 0, 64'h404,  0, 64'h408,  0, 0, 1, 0, 2);
      rows[12] = mk(0, 0, 64'h0,    1, 1, 0, 64'h408,  1, 64'h408,  0, 1, 1, 0, 2);
      rows[13] = mk(0, 1, 64'h3000, 1, 1, 0, 64'h408,  1, 64'h408,  0, 1, 1, 0, 2);
      rows[14] = mk(0, 0, 64'h0,    1, 1, 0, 64'h408,  1, 64'h3000, 1, 1, 0, 0, 3);
      rows[15] = mk(0, 0, 64'h0,    0, 0, 0, 64'h3000, 1, 64'h3000, 1, 0, 0, 0, 3);
      rows[16] = mk(0, 0, 64'h0,    0, 1, 1, 64'h3000, 0, 64'h3004, 0, 0, 1, 0, 3);
      rows[17] = mk(0, 1, 64'h5000, 0, 1, 0, 64'h3004, 1, 64'h3004, 1, 0, 0, 1, 3);
      rows[18] = mk(0, 0, 64'h0,    0, 1, 0, 64'h3004, 1, 64'h3004, 1, 0, 0, 1, 3);
      rows[19] = mk(1, 0, 64'h0,    0, 1, 0, 64'h3004, 1, 64'h3004, 1, 0, 0, 1, 3);
      rows[20] = mk(0, 0, 64'h0,    0, 1, 0, 64'h3004, 1, 64'h400,  1, 1, 0, 0, 4);
      rows[21] = mk(0, 1, 64'h6004, 0, 1, 1, 64'h400,  0, 64'h404,  0, 0, 1, 0, 4);
      rows[22] = mk(0, 1, 64'h7001, 0, 1, 0, 64'h404,  1, 64'h6004, 1, 1, 0, 0, 5);
      rows[23] = mk(0, 0, 64'h0,    0, 1, 0, 64'h6004, 1, 64'h7000, 1, 1, 0, 0, 6);
      rows[24] = mk(0, 0, 64'h0,    0, 1, 0, 64'h7000, 0, 64'h7004, 0, 0, 1, 0, 6);

      // Vector table from reset.
      reset_dut();
      for (int i = 0; i < 25; i++) apply_row(i);

      // Counter saturation, with a first target that makes pc+4 wrap.
      reset_dut();
      model_cycle("sat_boot");
      for (int k = 0; k < 17; k++) begin
         br_taken = 1'b1;
         br_target = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : 64'h1000 + 64'(k * 16);
         model_cycle("sat_req");
         br_taken = 1'b0;
         model_cycle("sat_redir");
      end
      chk("cnt_sat", 64'(redir_cnt), 64'd15);

      // Halt for 10 cycles; branches are ignored, then an exception wakes it.
      halt_req = 1'b1;
      model_cycle("halt_req");
      halt_req = 1'b0;
      frozen = pc_reg;
      for (int k = 0; k < 10; k++) begin
         br_taken = 1'($urandom_range(0, 1));
         br_target = {$urandom, $urandom};
         stall_req = 1'($urandom_range(0, 1));
         model_cycle("halt");
         chk("halt_pc_frozen", pc_reg, frozen);
      end
      idle_inputs();
      exc_req = 1'b1;
      model_cycle("halt_exc");
      exc_req = 1'b0;
      model_cycle("halt_wake");

      // Asynchronous reset in the middle of a REDIR cycle.
      br_taken = 1'b1; br_target = 64'h8000;
      model_cycle("pre_rst");
      idle_inputs();
      #1;
      chk("mid_redir_pc_in", pc_in, 64'h8000);
      #1;
      rst = 1'b0;
      #1;
      chk_reset_outs("async_rst");

      // Random stimulus against the model.
      reset_dut();
      for (int c = 0; c < 400; c++) begin
         exc_req    = ($urandom_range(0, 9) == 0);
         br_taken   = ($urandom_range(0, 4) == 0);
         br_target  = {$urandom, $urandom};
         stall_req  = ($urandom_range(0, 3) == 0);
         imem_ready = ($urandom_range(0, 4) != 0);
         halt_req   = ($urandom_range(0, 9) == 0);
         model_cycle("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
